// File: rtl/decoder3x8_pulse_if.sv
// rtl/decoder3x8_pulse_if.sv - code handshake and pulse-output bundle for decoder3x8_pulse
// The source owns code_in/code_valid; the decoder owns the ready, one-hot and status lines.
interface decoder3x8_pulse_if;
  logic [2:0] code_in;
  logic       code_valid;
  logic       code_ready;
  logic [7:0] out;
  logic       active;
  logic       done;
  logic       pend;

  modport master (
    output code_in,
    output code_valid,
    input  code_ready,
    input  out,
    input  active,
    input  done,
    input  pend
  );

  modport slave (
    input  code_in,
    input  code_valid,
    output code_ready,
    output out,
    output active,
    output done,
    output pend
  );
endinterface

// File: rtl/decoder3x8_pulse.sv
// rtl/decoder3x8_pulse.sv - registered 3-to-8 one-hot pulse decoder with a one-entry pending slot
// Each accepted code lights one line for PULSE_LEN cycles, then GAP_LEN zero cycles follow.
module decoder3x8_pulse #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input logic               clk,
  input logic               rst,
  decoder3x8_pulse_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GAP_LAST   = 8'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);
  localparam bit         HAS_GAP    = (GAP_LEN > 0);

  if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_pulse_len
    $error("decoder3x8_pulse: PULSE_LEN must be in 1..255");
  end
  if (GAP_LEN < 0 || GAP_LEN > 255) begin : g_bad_gap_len
    $error("decoder3x8_pulse: GAP_LEN must be in 0..255");
  end

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_cur_code;
  logic [2:0] r_pend_code;
  logic       r_pend;
  logic [7:0] r_out;
  logic       r_active;
  logic       r_done;

  state_t     w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic [2:0] w_cur_nxt;
  logic [2:0] w_pend_code_nxt;
  logic       w_pend_nxt;
  logic       w_slot_end;
  logic       w_xfer;

  assign bus.code_ready = !r_pend && !rst;
  assign w_xfer         = bus.code_valid && bus.code_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cur_nxt       = r_cur_code;
    w_pend_code_nxt = r_pend_code;
    w_pend_nxt      = r_pend;
    w_slot_end      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_state_nxt = S_DRIVE;
          w_cur_nxt   = bus.code_in;
          w_cnt_nxt   = PULSE_LAST;
        end
      end
      S_DRIVE: begin
        if (r_cnt == 8'd0) begin
          if (HAS_GAP) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = GAP_LAST;
          end else begin
            w_slot_end = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_GAP: begin
        if (r_cnt == 8'd0) begin
          w_slot_end = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase

    // The queued code always beats a fresh one; ready is low while pend is set anyway.
    if (w_slot_end) begin
      if (r_pend) begin
        w_state_nxt = S_DRIVE;
        w_cur_nxt   = r_pend_code;
        w_cnt_nxt   = PULSE_LAST;
        w_pend_nxt  = 1'b0;
      end else if (w_xfer) begin
        w_state_nxt = S_DRIVE;
        w_cur_nxt   = bus.code_in;
        w_cnt_nxt   = PULSE_LAST;
      end else begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    end

    if (w_xfer && (r_state != S_IDLE) && !w_slot_end) begin
      w_pend_nxt      = 1'b1;
      w_pend_code_nxt = bus.code_in;
    end
  end

  // Outputs are registered from next-state values so they align with the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_cur_code  <= 3'd0;
      r_pend_code <= 3'd0;
      r_pend      <= 1'b0;
      r_out       <= 8'h00;
      r_active    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cur_code  <= w_cur_nxt;
      r_pend_code <= w_pend_code_nxt;
      r_pend      <= w_pend_nxt;
      r_out       <= (w_state_nxt == S_DRIVE) ? (8'b1 << w_cur_nxt) : 8'h00;
      r_active    <= (w_state_nxt == S_DRIVE);
      r_done      <= (w_state_nxt == S_DRIVE) && (w_cnt_nxt == 8'd0);
    end
  end

  assign bus.out    = r_out;
  assign bus.active = r_active;
  assign bus.done   = r_done;
  assign bus.pend   = r_pend;

endmodule

// File: tb/tb_decoder3x8_pulse.sv
// tb/tb_decoder3x8_pulse.sv - self-checking bench for decoder3x8_pulse
// Reference is a slot schedule: each accepted code starts at max(accept edge, previous slot end).
module tb_decoder3x8_pulse;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = 3'd0;
  bit         sel = 1'b0;
  int         mpl = 4;
  int         mgl = 1;

  int checks = 0;
  int errors = 0;
  int t = 0;
  int slot_free = 0;
  int         q_acc[$];
  int         q_st[$];
  logic [2:0] q_cd[$];

  decoder3x8_pulse_if if_a ();
  decoder3x8_pulse_if if_b ();

  assign if_a.code_valid = in_valid && !sel;
  assign if_a.code_in    = in_code;
  assign if_b.code_valid = in_valid && sel;
  assign if_b.code_in    = in_code;

  decoder3x8_pulse #(.PULSE_LEN(4), .GAP_LEN(1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  decoder3x8_pulse #(.PULSE_LEN(1), .GAP_LEN(0)) u_b (.clk(clk), .rst(rst), .bus(if_b));

  always #5 clk = ~clk;

  // pending before edge u: accepted on an earlier edge but not started yet
  function automatic bit pend_at(int u);
    for (int i = 0; i < q_acc.size(); i++)
      if (q_acc[i] <= u - 1 && q_st[i] >= u) return 1'b1;
    return 1'b0;
  endfunction

  // {out, active, done, pend, ready} expected in the cycle following edge u
  function automatic logic [11:0] model_exp(int u);
    logic [7:0] o;
    logic       d;
    logic       p;
    o = 8'h00;
    d = 1'b0;
    for (int i = 0; i < q_st.size(); i++)
      if (q_st[i] <= u && u < q_st[i] + mpl) begin
        o = 8'b1 << q_cd[i];
        d = (u == q_st[i] + mpl - 1);
      end
    p = pend_at(u + 1);
    return {o, (o != 8'h00), d, p, (!rst && !p)};
  endfunction

  task automatic step(output logic [11:0] got, output logic [11:0] exp, output bit xfer);
    bit rdy_m;
    int s;
    rdy_m = !rst && !pend_at(t);
    @(posedge clk);
    xfer = 1'b0;
    if (rst) begin
      q_acc.delete(); q_st.delete(); q_cd.delete();
      slot_free = 0;
    end else if (in_valid && rdy_m) begin
      s = (t > slot_free) ? t : slot_free;
      q_acc.push_back(t); q_st.push_back(s); q_cd.push_back(in_code);
      slot_free = s + mpl + mgl;
      xfer = 1'b1;
    end
    @(negedge clk);
    exp = model_exp(t);
    if (sel) got = {if_b.out, if_b.active, if_b.done, if_b.pend, if_b.code_ready};
    else     got = {if_a.out, if_a.active, if_a.done, if_a.pend, if_a.code_ready};
    t++;
  endtask

  task automatic do_reset(input bit which);
    logic [11:0] g, e;
    bit x;
    sel = which;
    mpl = which ? 1 : 4;
    mgl = which ? 0 : 1;
    in_valid = 1'b0;
    rst = 1'b1;
    step(g, e, x);
    step(g, e, x);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [11:0] g, e;
    bit x;
    sel = 0; mpl = 4; mgl = 1;
    rst = 1'b1; in_valid = 1'b1; in_code = 3'd6;
    for (int i = 0; i < 3; i++) begin
      step(g, e, x);
      checks++;
      if (g !== 12'h000) begin errors++; $display("FAIL reset_state cyc%0d got %h exp %h", i, g, 12'h000); end
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (if_a.code_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", if_a.code_ready); end
    step(g, e, x);
    checks++;
    if (g !== e) begin errors++; $display("FAIL reset_idle got %h exp %h", g, e); end
  endtask

  task automatic test_reset_mid_pulse;
    logic [11:0] g, e;
    bit x;
    do_reset(0);
    in_valid = 1'b1; in_code = 3'd5;
    step(g, e, x);
    in_code = 3'd2;
    step(g, e, x);
    in_valid = 1'b0;
    checks++;
    if (g[1] !== 1'b1 || g[11:4] !== 8'h20) begin errors++; $display("FAIL midrst_setup got %h exp out 20 pend 1", g); end
    rst = 1'b1;
    step(g, e, x);
    checks++;
    if (g !== 12'h000) begin errors++; $display("FAIL midrst_during got %h exp %h", g, 12'h000); end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(g, e, x);
      checks++;
      if (g !== e || g[11:4] !== 8'h00) begin errors++; $display("FAIL midrst_after cyc%0d got %h exp %h", i, g, e); end
    end
  endtask

  task automatic test_single;
    logic [11:0] g, e;
    bit x;
    int n_on, done_at;
    do_reset(0);
    n_on = 0; done_at = -1;
    in_valid = 1'b1; in_code = 3'd3;
    for (int i = 0; i < 8; i++) begin
      step(g, e, x);
      if (x) in_valid = 1'b0;
      checks++;
      if (g !== e) begin errors++; $display("FAIL single cyc%0d got %h exp %h", i, g, e); end
      if (g[11:4] == 8'h08) n_on++;
      if (g[2]) done_at = i;
      if (i == 4) begin
        checks++;
        if (g[11:4] !== 8'h00) begin errors++; $display("FAIL single_gap got %h exp 00", g[11:4]); end
      end
    end
    checks++;
    if (n_on != 4 || done_at != 3) begin errors++; $display("FAIL single_len on %0d done_at %0d exp 4 and 3", n_on, done_at); end
    checks++;
    if (g[3] !== 1'b0 || g[0] !== 1'b1) begin errors++; $display("FAIL single_idle got %h exp active 0 ready 1", g); end
  endtask

  task automatic test_back_to_back;
    logic [11:0] g, e;
    bit x;
    int k;
    logic [7:0] dq[$];
    do_reset(0);
    k = 0; in_valid = 1'b1; in_code = 3'd0;
    for (int i = 0; i < 60; i++) begin
      step(g, e, x);
      if (x) begin k++; if (k < 8) in_code = 3'(k); else in_valid = 1'b0; end
      checks++;
      if (g !== e) begin errors++; $display("FAIL b2b cyc%0d got %h exp %h", i, g, e); end
      if (g[1] && g[0]) begin errors++; $display("FAIL b2b_ready_pend cyc%0d got ready 1 exp 0", i); end
      if (g[2]) dq.push_back(g[11:4]);
    end
    checks++;
    if (k != 8 || dq.size() != 8) begin errors++; $display("FAIL b2b_count sent %0d dones %0d exp 8 8", k, dq.size()); end
    for (int i = 0; i < dq.size() && i < 8; i++) begin
      checks++;
      if (dq[i] !== (8'b1 << i)) begin errors++; $display("FAIL b2b_order idx%0d got %h exp %h", i, dq[i], 8'b1 << i); end
    end
  endtask

  task automatic test_queue_full;
    logic [11:0] g, e;
    bit x;
    int k;
    logic [2:0] codes[3];
    logic [7:0] want[3];
    logic [7:0] dq[$];
    codes[0] = 3'd1; codes[1] = 3'd6; codes[2] = 3'd2;
    want[0] = 8'h02; want[1] = 8'h40; want[2] = 8'h04;
    do_reset(0);
    k = 0; in_valid = 1'b1; in_code = codes[0];
    for (int i = 0; i < 25; i++) begin
      step(g, e, x);
      if (x) begin k++; if (k < 3) in_code = codes[k]; else in_valid = 1'b0; end
      checks++;
      if (g !== e) begin errors++; $display("FAIL qfull cyc%0d got %h exp %h", i, g, e); end
      if (g[2]) dq.push_back(g[11:4]);
    end
    checks++;
    if (k != 3 || dq.size() != 3) begin errors++; $display("FAIL qfull_count sent %0d dones %0d exp 3 3", k, dq.size()); end
    for (int i = 0; i < dq.size() && i < 3; i++) begin
      checks++;
      if (dq[i] !== want[i]) begin errors++; $display("FAIL qfull_order idx%0d got %h exp %h", i, dq[i], want[i]); end
    end
  endtask

  task automatic test_gap0_repeat;
    logic [11:0] g, e;
    bit x;
    int k, first;
    logic [2:0] codes[3];
    logic [7:0] want[3];
    logic [11:0] seen[$];
    codes[0] = 3'd7; codes[1] = 3'd7; codes[2] = 3'd0;
    want[0] = 8'h80; want[1] = 8'h80; want[2] = 8'h01;
    do_reset(1);
    k = 0; first = -1; in_valid = 1'b1; in_code = codes[0];
    for (int i = 0; i < 8; i++) begin
      step(g, e, x);
      if (x) begin k++; if (k < 3) in_code = codes[k]; else in_valid = 1'b0; end
      checks++;
      if (g !== e) begin errors++; $display("FAIL gap0 cyc%0d got %h exp %h", i, g, e); end
      if (g[11:4] != 8'h00) begin
        if (first < 0) first = i;
        if (i - first < 3) seen.push_back(g);
      end
    end
    checks++;
    if (seen.size() != 3) begin errors++; $display("FAIL gap0_len got %0d exp 3", seen.size()); end
    for (int i = 0; i < seen.size(); i++) begin
      checks++;
      if (seen[i][11:4] !== want[i] || seen[i][2] !== 1'b1) begin
        errors++; $display("FAIL gap0_seq idx%0d got %h exp out %h done 1", i, seen[i], want[i]);
      end
    end
  endtask

  task automatic test_pass_through;
    logic [11:0] g, e;
    bit x;
    do_reset(0);
    in_valid = 1'b1; in_code = 3'd3;
    step(g, e, x);
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(g, e, x);
      checks++;
      if (g !== e) begin errors++; $display("FAIL pass cyc%0d got %h exp %h", i, g, e); end
    end
    in_valid = 1'b1; in_code = 3'd4;
    step(g, e, x);
    in_valid = 1'b0;
    checks++;
    if (g[11:4] !== 8'h10 || g[1] !== 1'b0 || !x) begin
      errors++; $display("FAIL pass_through got %h xfer %0b exp out 10 pend 0", g, x);
    end
    checks++;
    if (g !== e) begin errors++; $display("FAIL pass_model got %h exp %h", g, e); end
  endtask

  task automatic test_random(input bit which, input int ncyc);
    logic [11:0] g, e;
    bit x;
    int bad;
    do_reset(which);
    bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      step(g, e, x);
      checks++;
      if (g !== e) begin
        errors++;
        if (bad < 10) $display("FAIL random%0d cyc%0d got %h exp %h", which, i, g, e);
        bad++;
      end
      rst = ($urandom_range(0, 199) == 0);
      if (x || !in_valid) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_code  = 3'($urandom_range(0, 7));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_reset_mid_pulse;
    test_single;
    test_back_to_back;
    test_queue_full;
    test_pass_through;
    test_gap0_repeat;
    test_random(0, 1500);
    test_random(1, 1500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
